cnt_ld_arb_ctrl: RTL and testbench

Two-requester interval controller for the 4-bit loadable binary counter. It arbitrates round-robin between two requesters, each supplying a 4-bit preset. It then sequences the counter: parallel-load the winner's preset, count up to the terminal carry, and return a one-cycle done pulse to the winner. It sits beside the counter and drives its load/count/data inputs, taking the counter's carry output as its only feedback.

---
 rtl/cnt_ld_arb_ctrl.sv | 134 +++++++++++++
 tb/tb_cnt_ld_arb_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cnt_ld_arb_ctrl.sv
// cnt_ld_arb_ctrl: two-requester round-robin interval controller for a
// CNT_W-bit loadable up-counter. The winner's preset is loaded, the counter
// runs to its terminal carry, and a one-cycle done pulse goes back to the winner.
// Optional feature macro: CNT_LD_ARB_ABORT_EN adds abort_i, which cancels
// an interval in LOAD or RUN without producing a done pulse.
module cnt_ld_arb_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [CNT_W-1:0] pre0_i4,
  input  logic [CNT_W-1:0] pre1_i4,
`ifdef CNT_LD_ARB_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             C_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic             ld_o,
  output logic             cnt_o,
  output logic [CNT_W-1:0] data_o4,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;   // 0: requester 0 owns, 1: requester 1
  logic             last_q,  last_d;    // last-served requester
  logic [CNT_W-1:0] preset_q, preset_d;
  logic             win;
  logic             abort_w;

  logic             gnt0_q, gnt1_q, done0_q, done1_q, ld_q, cnt_q, busy_q;
  logic [CNT_W-1:0] data_q;

`ifdef CNT_LD_ARB_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // Round-robin winner: a lone request always wins, a tie goes to the
  // requester that was not served last.
  always_comb begin
    win = 1'b0;
    if (req0_i && req1_i) win = ~last_q;
    else                  win = req1_i;
  end

  // Next-state, owner, pointer and preset-capture logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    preset_d = preset_q;
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          owner_d  = win;
          preset_d = win ? pre1_i4 : pre0_i4;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (abort_w) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_w) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else if (C_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; outputs are registered from the next-state decode so
  // they always equal a decode of the current registered state/owner/preset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      preset_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      ld_q     <= 1'b0;
      cnt_q    <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      preset_q <= preset_d;
      gnt0_q   <= (state_d != IDLE) && !owner_d;
      gnt1_q   <= (state_d != IDLE) &&  owner_d;
      done0_q  <= (state_d == DONE) && !owner_d;
      done1_q  <= (state_d == DONE) &&  owner_d;
      ld_q     <= (state_d == LOAD);
      cnt_q    <= (state_d == RUN);
      busy_q   <= (state_d != IDLE);
      data_q   <= ((state_d == LOAD) || (state_d == RUN)) ? preset_d : '0;
    end
  end

  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;
  assign ld_o    = ld_q;
  assign cnt_o   = cnt_q;
  assign busy_o  = busy_q;
  assign data_o4 = data_q;

endmodule

// File: tb/tb_cnt_ld_arb_ctrl.sv
// Bench for cnt_ld_arb_ctrl: directed steps then random traffic, checked
// against an interval-timeline model (cycle offset within the interval).
module tb_cnt_ld_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] pre0 = '0, pre1 = '0;
  logic       abort = 1'b0;
  logic       gnt0, gnt1, done0, done1, ld, cnt, busy;
  logic [3:0] data;
  logic       carry;
  logic [3:0] cval = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gcyc = 0;

  // Interval model: m_t = 0 idle, 1 load, 2..17-P run, 18-P done.
  int m_t = 0;
  int m_P = 0;
  bit m_owner = 1'b0;
  bit m_last = 1'b1;

  always #5 clk = ~clk;

  cnt_ld_arb_ctrl #(.CNT_W(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req0_i  (req0),
    .req1_i  (req1),
    .pre0_i4 (pre0),
    .pre1_i4 (pre1),
`ifdef CNT_LD_ARB_ABORT_EN
    .abort_i (abort),
`endif
    .C_i     (carry),
    .gnt0_o  (gnt0),
    .gnt1_o  (gnt1),
    .done0_o (done0),
    .done1_o (done1),
    .ld_o    (ld),
    .cnt_o   (cnt),
    .data_o4 (data),
    .busy_o  (busy)
  );

  // Behavioural 4-bit loadable counter with terminal carry.
  always @(posedge clk) begin
    if (ld)       cval <= data;
    else if (cnt) cval <= cval + 4'd1;
  end
  assign carry = cnt && !ld && (cval == 4'hF);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    bit w;
    int last_run;
    bit ab;
    ab = 1'b0;
`ifdef CNT_LD_ARB_ABORT_EN
    ab = abort;
`endif
    // advance model with the inputs the DUT will sample on this edge
    if (rst) begin
      m_t = 0; m_owner = 1'b0; m_last = 1'b1;
    end else if (m_t == 0) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? !m_last : req1;
        m_owner = w;
        m_P = w ? int'(pre1) : int'(pre0);
        m_t = 1;
      end
    end else if (ab && m_t <= 17 - m_P) begin
      m_last = m_owner; m_t = 0;
    end else if (m_t == 18 - m_P) begin
      m_last = m_owner; m_t = 0;
    end else begin
      m_t++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (m_t == 1) gcyc = cyc - 1;
    last_run = 17 - m_P;
    chk("gnt0", gnt0, (m_t != 0) && !m_owner);
    chk("gnt1", gnt1, (m_t != 0) &&  m_owner);
    chk("ld", ld, m_t == 1);
    chk("cnt", cnt, (m_t >= 2) && (m_t <= last_run));
    chk("done0", done0, (m_t == 18 - m_P) && !m_owner);
    chk("done1", done1, (m_t == 18 - m_P) &&  m_owner);
    chk("busy", busy, m_t != 0);
    if (m_t == 0) chk("data_idle", data, 0);
    else if (m_t <= last_run) chk("data", data, m_P);
    if (done0 || done1) begin
      chk("latency", cyc - gcyc, 18 - m_P);
      chk("wrap", cval, 0);
    end
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    // single request, preset 0xC
    req0 = 1'b1; pre0 = 4'hC;
    tick();
    req0 = 1'b0; pre0 = 4'h5;
    repeat (8) tick();
    // both held: alternate grants
    req0 = 1'b1; req1 = 1'b1; pre0 = 4'hE; pre1 = 4'h3;
    repeat (40) tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (20) tick();
    // preset 0xF
    req1 = 1'b1; pre1 = 4'hF;
    tick();
    req1 = 1'b0;
    repeat (5) tick();
    // preset 0x0
    req0 = 1'b1; pre0 = 4'h0;
    tick();
    req0 = 1'b0;
    repeat (20) tick();
    // reset mid-RUN, then tie goes to req0
    req1 = 1'b1; pre1 = 4'h2;
    tick();
    req1 = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; pre0 = 4'hD; pre1 = 4'hA;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();
`ifdef CNT_LD_ARB_ABORT_EN
    // abort in RUN hands the counter to the pending requester
    req0 = 1'b1; req1 = 1'b1; pre0 = 4'h0; pre1 = 4'hC;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (10) tick();
`endif
    // random traffic
    for (int i = 0; i < 400; i++) begin
      req0 = ($urandom_range(0, 9) < 6);
      req1 = ($urandom_range(0, 9) < 6);
      pre0 = 4'($urandom);
      pre1 = 4'($urandom);
      rst  = ($urandom_range(0, 63) == 0);
`ifdef CNT_LD_ARB_ABORT_EN
      abort = ($urandom_range(0, 31) == 0);
`endif
      tick();
    end
    rst = 1'b0; abort = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
